// File: rtl/nibble_pack_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module : nibble_pack_fifo_pkg
// Brief  : Shared widths, pad nibble and pointer-width helper for the packer.
// Rev    : 1.0  initial release
// ============================================================================
package nibble_pack_fifo_pkg;

  localparam int BYTE_W = 8;
  localparam int NIB_W  = 4;
  localparam logic [NIB_W-1:0] PAD_NIB = 4'h0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_pack_fifo_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module : byte_fifo
// Brief  : DEPTH x 8 FIFO with wrap-bit pointers and a zeroed head when empty.
// Rev    : 1.0  initial release
// ============================================================================
module byte_fifo
  import nibble_pack_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [BYTE_W-1:0]       push_data,
  input  logic                    pop,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   level,
  output logic [BYTE_W-1:0]       head
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [BYTE_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;

  // The extra pointer bit tells full apart from empty when the indices match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign level = wr_ptr_q - rd_ptr_q;
  assign head  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nibble_pack_fifo.sv
`default_nettype none
// ============================================================================
// Module : nibble_pack_fifo
// Brief  : Packs nibbles (first nibble high) into bytes and buffers them.
// Rev    : 1.0  initial release
// ============================================================================
module nibble_pack_fifo #(
  parameter int DEPTH = 4,
  parameter int NIB_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [NIB_W-1:0]        in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [2*NIB_W-1:0]      out_data,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level
);

  import nibble_pack_fifo_pkg::*;

  logic               half_q, half_d;
  logic [NIB_W-1:0]   hold_q, hold_d;
  logic               fifo_full;
  logic               fifo_empty;
  logic               accept;
  logic               push;
  logic [BYTE_W-1:0]  push_data;

  // A high nibble can still be parked in hold while the FIFO is full.
  assign in_ready  = ~fifo_full | (~half_q & ~in_last);
  assign out_valid = ~fifo_empty;

  always_comb begin
    half_d    = half_q;
    hold_d    = hold_q;
    push      = 1'b0;
    push_data = {hold_q, in_data};
    accept    = in_valid & in_ready;
    if (accept) begin
      if (half_q) begin
        push   = 1'b1;
        half_d = 1'b0;
      end else if (in_last) begin
        push      = 1'b1;
        push_data = {in_data, PAD_NIB};
      end else begin
        hold_d = in_data;
        half_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q <= 1'b0;
      hold_q <= '0;
    end else begin
      half_q <= half_d;
      hold_q <= hold_d;
    end
  end

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_byte_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (out_valid & out_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level),
    .head      (out_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_nibble_pack_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_nibble_pack_fifo
// Brief  : Self-checking bench: directed vector table, async reset, random vs model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_nibble_pack_fifo;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic          v;
    logic [3:0]    d;
    logic          l;
    logic          r;
    logic          ev;
    logic [7:0]    ed;
    logic [LW-1:0] el;
    logic          er;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [3:0]    in_data = 4'h0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_ready = 1'b0;
  logic [LW-1:0] level;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t tbl[$];

  // behavioural reference: byte queue plus a pending high nibble
  logic [7:0] mq[$];
  logic       m_half;
  logic [3:0] m_hold;

  always #5 clk = ~clk;

  nibble_pack_fifo #(.DEPTH(DEPTH), .NIB_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level)
  );

  function automatic vec_t mk(input logic v, input logic [3:0] d, input logic l, input logic r,
                              input logic ev, input logic [7:0] ed, input int el, input logic er);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.r = r;
    t.ev = ev; t.ed = ed; t.el = LW'(el); t.er = er;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1: drive, check mid-cycle, advance to next posedge+1.
  task automatic step(input vec_t t, input string tag);
    in_valid  = t.v;
    in_data   = t.d;
    in_last   = t.l;
    out_ready = t.r;
    #3;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(t.ev));
    chk({tag, ".out_data"},  32'(out_data),  32'(t.ed));
    chk({tag, ".level"},     32'(level),     32'(t.el));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(t.er));
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_half = 1'b0;
    m_hold = 4'h0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] d, input logic l, input logic r,
                            input string tag);
    vec_t t;
    logic full, rdy;
    full = (mq.size() == DEPTH);
    rdy  = !full || (!m_half && !l);
    t = mk(v, d, l, r, mq.size() != 0, (mq.size() != 0) ? mq[0] : 8'h00, mq.size(), rdy);
    step(t, tag);
    if (mq.size() != 0 && r) void'(mq.pop_front());
    if (v && rdy) begin
      if (m_half) begin
        mq.push_back({m_hold, d});
        m_half = 1'b0;
      end else if (l) begin
        mq.push_back({d, 4'h0});
      end else begin
        m_hold = d;
        m_half = 1'b1;
      end
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    // reset held for two cycles
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.out_data",  32'(out_data),  32'h00);
    chk("reset.level",     32'(level),     32'd0);
    chk("reset.in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;

    // A,5 -> A5 visible next cycle then popped
    tbl.push_back(mk(1, 4'hA, 0, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(1, 4'h5, 0, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 4'h0, 0, 1, 1, 8'hA5, 1, 1));
    tbl.push_back(mk(0, 4'h0, 0, 1, 0, 8'h00, 0, 1));
    // fill with 0..8 under backpressure; 8 parked in hold while full
    for (int i = 0; i <= 8; i++)
      tbl.push_back(mk(1, 4'(i), 0, 0, i >= 2, (i >= 2) ? 8'h01 : 8'h00, i / 2, 1));
    // full with half pending blocks nibble 9, then drain with push/pop overlap
    tbl.push_back(mk(1, 4'h9, 0, 0, 1, 8'h01, 4, 0));
    tbl.push_back(mk(1, 4'h9, 0, 1, 1, 8'h01, 4, 0));
    tbl.push_back(mk(1, 4'h9, 0, 1, 1, 8'h23, 3, 1));
    tbl.push_back(mk(1, 4'hA, 0, 1, 1, 8'h45, 3, 1));
    tbl.push_back(mk(1, 4'hB, 0, 1, 1, 8'h67, 2, 1));
    tbl.push_back(mk(1, 4'hC, 0, 1, 1, 8'h89, 2, 1));
    tbl.push_back(mk(1, 4'hD, 0, 1, 1, 8'hAB, 1, 1));
    tbl.push_back(mk(1, 4'hE, 0, 1, 1, 8'hCD, 1, 1));
    tbl.push_back(mk(1, 4'hF, 0, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 4'h0, 0, 1, 1, 8'hEF, 1, 1));
    tbl.push_back(mk(0, 4'h0, 0, 1, 0, 8'h00, 0, 1));
    // single nibble with last pads; last on second nibble is ignored
    tbl.push_back(mk(1, 4'h3, 1, 0, 0, 8'h00, 0, 1));
    tbl.push_back(mk(1, 4'hD, 0, 0, 1, 8'h30, 1, 1));
    tbl.push_back(mk(1, 4'hE, 0, 0, 1, 8'h30, 1, 1));
    tbl.push_back(mk(1, 4'h7, 0, 1, 1, 8'h30, 2, 1));
    tbl.push_back(mk(1, 4'h8, 1, 1, 1, 8'hDE, 1, 1));
    tbl.push_back(mk(0, 4'h0, 0, 1, 1, 8'h78, 1, 1));
    tbl.push_back(mk(0, 4'h0, 0, 0, 0, 8'h00, 0, 1));

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // byte 12 stored, B pending, then asynchronous reset mid-cycle
    step(mk(1, 4'h1, 0, 0, 0, 8'h00, 0, 1), "ar0");
    step(mk(1, 4'h2, 0, 0, 0, 8'h00, 0, 1), "ar1");
    step(mk(1, 4'hB, 0, 0, 1, 8'h12, 1, 1), "ar2");
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset.out_valid", 32'(out_valid), 32'd0);
    chk("areset.out_data",  32'(out_data),  32'h00);
    chk("areset.level",     32'(level),     32'd0);
    chk("areset.in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(mk(1, 4'hC, 0, 1, 0, 8'h00, 0, 1), "ar3");
    step(mk(1, 4'h4, 0, 1, 0, 8'h00, 0, 1), "ar4");
    step(mk(0, 4'h0, 0, 1, 1, 8'hC4, 1, 1), "ar5");
    step(mk(0, 4'h0, 0, 1, 0, 8'h00, 0, 1), "ar6");

    // randomized traffic against the reference model
    pulse_reset();
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 400; i++) begin
      model_step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 9) < 2,
                 (i % 100 < 40) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6),
                 $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
